wb_timer_array: RTL and testbench

- Parametrised multi-channel Wishbone timer; successor to the single-counter bus timer in the nexys4-ddr SoC.
- Provides NUM_CH independent WIDTH-bit up-counters sharing one programmable prescaler.
- Each channel has a compare match, periodic or one-shot mode, and per-channel interrupt status/enable.
- A single level irq output goes to the core's interrupt input; one pipelined Wishbone slave port, no stall.

---
 rtl/wb_timer_array.sv | 183 ++++++++++++++++++
 tb/tb_wb_timer_array.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer_array.sv
// Multi-channel compare timer with shared prescaler behind a pipelined, never-stalling Wishbone slave.
// Build option TIMER_CAPTURE_EN adds per-channel input capture with its own status/enable bits.
module wb_timer_array #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 32,
   parameter int PRE_W  = 16,
   parameter int ADR_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_cyc,
   input  logic              wb_stb,
   input  logic              wb_we,
   input  logic [ADR_W-1:0]  wb_adr,
   input  logic [3:0]        wb_sel,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack,
   output logic              wb_err,
   output logic              wb_stall,
   input  logic [NUM_CH-1:0] capture_i,
   output logic              irq
);

`ifdef TIMER_CAPTURE_EN
   localparam int ST_W = 2 * NUM_CH;
`else
   localparam int ST_W = NUM_CH;
`endif

   logic              valid;
   logic              mapped;
   logic              wr;
   logic              tick;
   logic [1:0]        reg_sel;
   int                blk;
   logic [31:0]       lane;
   logic [31:0]       rdata;
   logic [PRE_W-1:0]  prescale;
   logic [PRE_W-1:0]  pre_cnt;
   logic [ST_W-1:0]   irq_status;
   logic [ST_W-1:0]   irq_en;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] oneshot;
   logic [WIDTH-1:0]  count   [NUM_CH];
   logic [WIDTH-1:0]  compare [NUM_CH];
   logic              unused_adr;

`ifdef TIMER_CAPTURE_EN
   logic [NUM_CH-1:0] cap_q;
   logic [NUM_CH-1:0] cap_rise;
   logic [WIDTH-1:0]  capture [NUM_CH];
   assign cap_rise = capture_i & ~cap_q;
`else
   logic              unused_capture;
   assign unused_capture = ^capture_i;
`endif

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                         input logic [31:0] m);
      return (old & ~m) | (dat & m);
   endfunction

   // blk 0 holds the global registers; blk i+1 is channel i.
   assign valid      = wb_cyc & wb_stb;
   assign reg_sel    = wb_adr[3:2];
   assign blk        = int'(wb_adr[ADR_W-1:4]);
   assign lane       = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
   assign mapped     = (blk == 0) ? (reg_sel != 2'd3) : (blk <= NUM_CH);
   assign wr         = valid & wb_we & mapped;
   assign tick       = (pre_cnt == prescale);
   assign wb_stall   = 1'b0;
   assign irq        = |(irq_status & irq_en);
   assign unused_adr = ^wb_adr[1:0];

   always_comb begin
      rdata = '0;
      if (blk == 0) begin
         case (reg_sel)
            2'd0:    rdata = 32'(prescale);
            2'd1:    rdata = 32'(irq_status);
            2'd2:    rdata = 32'(irq_en);
            default: rdata = '0;
         endcase
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (blk == i + 1) begin
            case (reg_sel)
               2'd0:    rdata = {29'd0, oneshot[i], 1'b0, en[i]};
               2'd1:    rdata = 32'(count[i]);
               2'd2:    rdata = 32'(compare[i]);
`ifdef TIMER_CAPTURE_EN
               default: rdata = 32'(capture[i]);
`else
               default: rdata = '0;
`endif
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack     <= 1'b0;
         wb_err     <= 1'b0;
         wb_dat_o   <= '0;
         prescale   <= '0;
         pre_cnt    <= '0;
         irq_status <= '0;
         irq_en     <= '0;
         en         <= '0;
         oneshot    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            count[i]   <= '0;
            compare[i] <= '0;
`ifdef TIMER_CAPTURE_EN
            capture[i] <= '0;
`endif
         end
`ifdef TIMER_CAPTURE_EN
         cap_q <= '0;
`endif
      end else begin
         wb_ack   <= valid & mapped;
         wb_err   <= valid & ~mapped;
         wb_dat_o <= (valid & mapped & ~wb_we) ? rdata : '0;

         if (tick || (wr && blk == 0 && reg_sel == 2'd0))
            pre_cnt <= '0;
         else
            pre_cnt <= pre_cnt + 1'b1;

         // W1C sits before the per-channel sets so a same-cycle set survives.
         if (wr && blk == 0) begin
            case (reg_sel)
               2'd0:    prescale   <= PRE_W'(merge(32'(prescale), wb_dat_i, lane));
               2'd1:    irq_status <= irq_status & ~ST_W'(wb_dat_i & lane);
               2'd2:    irq_en     <= ST_W'(merge(32'(irq_en), wb_dat_i, lane));
               default: ;
            endcase
         end

         for (int i = 0; i < NUM_CH; i++) begin
            if (tick && en[i]) begin
               if (count[i] == compare[i]) begin
                  irq_status[i] <= 1'b1;
                  count[i]      <= '0;
                  if (oneshot[i])
                     en[i] <= 1'b0;
               end else begin
                  count[i] <= count[i] + 1'b1;
               end
            end
            // Later assignments win: COUNT write over CLR over tick.
            if (wr && blk == i + 1) begin
               case (reg_sel)
                  2'd0: begin
                     if (wb_sel[0]) begin
                        en[i]      <= wb_dat_i[0];
                        oneshot[i] <= wb_dat_i[2];
                        if (wb_dat_i[1])
                           count[i] <= '0;
                     end
                  end
                  2'd1:    count[i]   <= WIDTH'(merge(32'(count[i]), wb_dat_i, lane));
                  2'd2:    compare[i] <= WIDTH'(merge(32'(compare[i]), wb_dat_i, lane));
                  default: ;
               endcase
            end
`ifdef TIMER_CAPTURE_EN
            if (cap_rise[i]) begin
               capture[i]           <= count[i];
               irq_status[NUM_CH+i] <= 1'b1;
            end
`endif
         end
`ifdef TIMER_CAPTURE_EN
         cap_q <= capture_i;
`endif
      end
   end

endmodule

// File: tb/tb_wb_timer_array.sv
// Scoreboard bench for wb_timer_array (NUM_CH=4, WIDTH=8): bus responses are queued at issue and checked by a monitor.
module tb_wb_timer_array;
   localparam int NUM_CH = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [7:0]        wb_adr = '0;
   logic [3:0]        wb_sel = '0;
   logic [31:0]       wb_dat_i = '0;
   logic [31:0]       wb_dat_o;
   logic              wb_ack, wb_err, wb_stall, irq;
   logic [NUM_CH-1:0] capture_i = '0;

   int vectors = 0;
   int miscompares = 0;
   int cyc_cnt = 0;

   typedef struct {
      string       name;
      logic        err;
      logic        chk_dat;
      logic [31:0] dat;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   wb_timer_array #(.NUM_CH(NUM_CH), .WIDTH(8), .PRE_W(16), .ADR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
      .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall), .capture_i(capture_i),
      .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every ack/err must match the oldest outstanding access, one cycle after issue.
   always @(negedge clk) begin
      exp_t e;
      if (wb_ack === 1'b1 || wb_err === 1'b1) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_response: ack=%b err=%b with nothing outstanding", wb_ack, wb_err);
         end else begin
            e = sb.pop_front();
            check({e.name, "/hs"}, {30'd0, wb_ack, wb_err, 32'(cyc_cnt)},
                  {30'd0, ~e.err, e.err, 32'(e.cyc + 1)});
            if (e.chk_dat)
               check({e.name, "/dat"}, 64'(wb_dat_o), 64'(e.dat));
         end
      end
   end

   task automatic sync;
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic err, input logic chk,
                      input logic [31:0] edat, input string name);
      exp_t e;
      e.name = name; e.err = err; e.chk_dat = chk; e.dat = edat; e.cyc = cyc_cnt;
      sb.push_back(e);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat; wb_sel = sel;
      sync();
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
      bus(1'b1, adr, dat, 4'hF, 1'b0, 1'b0, 32'd0, $sformatf("wr_%02h", adr));
   endtask

   task automatic rd(input logic [7:0] adr, input logic [31:0] edat, input string name);
      bus(1'b0, adr, 32'd0, 4'h0, 1'b0, 1'b1, edat, name);
   endtask

   task automatic wait_irq(input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (irq === 1'b1) begin
            at = cyc_cnt;
            break;
         end
      end
      if (at < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL irq_wait: irq not seen within %0d cycles", maxc);
      end
      sync();
   endtask

   initial begin
      int t1, t2;
      logic [7:0] a;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      sync();
      // Access in flight when reset hits must never be acknowledged.
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 8'h00;
      @(negedge clk) rst_n = 1'b0;
      sync();
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(negedge clk);
      check("rst_drop_ack", {62'd0, wb_ack, wb_err}, 64'd0);
      sync();
      rst_n = 1'b1;
      sync();

      rd(8'h00, 0, "rst_prescale");
      rd(8'h04, 0, "rst_status");
      rd(8'h08, 0, "rst_enable");
      for (int ch = 0; ch < NUM_CH; ch++)
         for (int r = 0; r < 4; r++) begin
            a = 8'(16 + 16 * ch + 4 * r);
            rd(a, 0, $sformatf("rst_ch%0d_r%0d", ch, r));
         end
      check("rst_irq", 64'(irq), 64'd0);
      check("stall", 64'(wb_stall), 64'd0);

      // Periodic ch0: (3+1) * (5+1) = 24 cycles between matches.
      wr(8'h00, 3);
      wr(8'h18, 5);
      wr(8'h08, 1);
      wr(8'h10, 1);
      wait_irq(60, t1);
      repeat (3) @(negedge clk);
      check("irq_held", 64'(irq), 64'd1);
      sync();
      wr(8'h04, 1);
      @(negedge clk);
      check("irq_w1c", 64'(irq), 64'd0);
      sync();
      wait_irq(40, t2);
      check("period_24", 64'(t2 - t1), 64'd24);
      wr(8'h10, 0);
      wr(8'h04, 32'hF);
      wr(8'h00, 0);
      rd(8'h04, 0, "status_cleared");
      check("irq_cleared", 64'(irq), 64'd0);

      // One-shot ch1, COMPARE=2, tick every cycle: status sets on the 3rd tick.
      wr(8'h28, 2);
      wr(8'h20, 5);
      rd(8'h04, 0, "os_tick1");
      rd(8'h04, 0, "os_tick2");
      rd(8'h04, 0, "os_tick3");
      rd(8'h04, 2, "os_status");
      rd(8'h20, 4, "os_ctrl_en_cleared");
      rd(8'h24, 0, "os_count_zero");
      check("os_irq_masked", 64'(irq), 64'd0);
      wr(8'h04, 2);

      // Wrap on ch2: 0xFE -> 0xFF -> 0x00 without status, match at 0x10.
      wr(8'h38, 32'h10);
      wr(8'h34, 32'hFE);
      wr(8'h30, 1);
      rd(8'h34, 32'hFE, "wrap_fe");
      rd(8'h34, 32'hFF, "wrap_ff");
      rd(8'h34, 32'h00, "wrap_00");
      rd(8'h34, 32'h01, "wrap_01");
      for (int i = 0; i < 16; i++)
         rd(8'h04, (i == 15) ? 32'h4 : 32'h0, $sformatf("wrap_status_%0d", i));
      wr(8'h30, 0);
      rd(8'h34, 2, "wrap_count_after_stop");
      wr(8'h04, 4);

      // ch3: bus COUNT write beats a pending tick; set beats same-cycle W1C.
      wr(8'h48, 32'hFF);
      wr(8'h40, 1);
      wr(8'h44, 32'h55);
      rd(8'h44, 32'h55, "cnt_wr_wins");
      rd(8'h44, 32'h56, "cnt_after_tick");
      wr(8'h48, 0);
      wr(8'h44, 0);
      wr(8'h04, 8);
      rd(8'h04, 8, "set_beats_w1c");
      rd(8'h44, 0, "cmp0_count_stays0");
      wr(8'h40, 0);
      wr(8'h04, 8);
      rd(8'h04, 0, "ch3_status_cleared");

      // Unmapped offsets.
      bus(1'b0, 8'h0C, 0, 4'h0, 1'b1, 1'b1, 0, "err_rd_0c");
      bus(1'b0, 8'h50, 0, 4'h0, 1'b1, 1'b1, 0, "err_rd_ch4");
      bus(1'b1, 8'h0C, 32'h7, 4'hF, 1'b1, 1'b1, 0, "err_wr_0c");
      bus(1'b1, 8'h58, 32'h77, 4'hF, 1'b1, 1'b1, 0, "err_wr_ch4cmp");
      rd(8'h00, 0, "err_no_prescale_change");
      rd(8'h18, 5, "err_no_alias_ch0cmp");

      // Byte lanes.
      bus(1'b1, 8'h00, 32'h0000_1234, 4'b0001, 1'b0, 1'b0, 0, "sel_lane0");
      bus(1'b1, 8'h00, 32'hFFFF_AB00, 4'b0010, 1'b0, 1'b0, 0, "sel_lane1");
      rd(8'h00, 32'hAB34, "sel_prescale");
      wr(8'h00, 0);

`ifdef TIMER_CAPTURE_EN
      wr(8'h34, 7);
      capture_i = 4'b0100;
      sync();
      capture_i = '0;
      rd(8'h3C, 7, "cap_value");
      rd(8'h04, 32'h40, "cap_status");
      wr(8'h08, 32'h40);
      @(negedge clk);
      check("cap_irq", 64'(irq), 64'd1);
      sync();
      wr(8'h04, 32'h40);
      rd(8'h04, 0, "cap_w1c");
`else
      wr(8'h3C, 32'h12);
      capture_i = 4'hF;
      sync();
      capture_i = '0;
      rd(8'h3C, 0, "cap_reads_zero");
      rd(8'h04, 0, "cap_no_status");
`endif

      repeat (5) @(posedge clk);
      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
